// File: rtl/mux_pipe_n.sv
// mux_pipe_n: pipelined radix-2**s N-to-1 selector with a valid/ready handshake.
// There is one register stage per s select bits. Unpopulated leaves read as zero.
module mux_pipe_n #(
  parameter int unsigned n       = 4,
  parameter int unsigned address = 10,
  parameter int unsigned s       = 5,
  parameter int unsigned depth   = 2**address
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [n-1:0]       data_i [0:depth-1],
  input  logic [address-1:0] sel_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [n-1:0]       data_o,
  output logic               err_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int unsigned L = address / s;
  localparam int unsigned R = 2**s;

  if (address % s != 0) begin : g_bad_radix
    $error("mux_pipe_n: address must be a multiple of s");
  end
  if (depth < 1 || depth > 2**address) begin : g_bad_depth
    $error("mux_pipe_n: depth must lie in 1..2**address");
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    // Select bits still unresolved on entry to this stage.
    localparam int unsigned IN_W = address - k*s;
    localparam int unsigned NOUT = 2**(IN_W - s);

    logic [n-1:0]    grp [NOUT][R];
    logic [n-1:0]    red [NOUT];
    logic [n-1:0]    part_q [NOUT];
    logic [IN_W-1:0] in_sel;
    logic            in_v;
    logic            in_e;
    logic            v_q;
    logic            e_q;
    logic            rdy;

    if (k == 0) begin : g_src
      assign in_sel = sel_i;
      assign in_v   = valid_i;
      assign in_e   = (32'(sel_i) >= depth);
      // Any sel >= depth lands on a zero leaf, so an errored request yields data_o = 0.
      for (genvar j = 0; j < NOUT; j++) begin : g_grp
        for (genvar r = 0; r < R; r++) begin : g_leaf
          if (j*R + r < depth) begin : g_pop
            assign grp[j][r] = data_i[j*R + r];
          end else begin : g_empty
            assign grp[j][r] = '0;
          end
        end
      end
    end else begin : g_src
      assign in_sel = g_stage[k-1].g_sel.sel_q;
      assign in_v   = g_stage[k-1].v_q;
      assign in_e   = g_stage[k-1].e_q;
      for (genvar j = 0; j < NOUT; j++) begin : g_grp
        for (genvar r = 0; r < R; r++) begin : g_leaf
          assign grp[j][r] = g_stage[k-1].part_q[j*R + r];
        end
      end
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_red
      assign red[j] = grp[j][in_sel[s-1:0]];
    end

    // An empty stage always accepts, which lets bubbles collapse under a stall.
    if (k == L-1) begin : g_rdy
      assign rdy = !v_q || ready_i;
    end else begin : g_rdy
      assign rdy = !v_q || g_stage[k+1].rdy;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        v_q    <= 1'b0;
        e_q    <= 1'b0;
        part_q <= '{default: '0};
      end else if (rdy) begin
        v_q <= in_v;
        if (in_v) begin
          part_q <= red;
          e_q    <= in_e;
        end
      end
    end

    if (k < L-1) begin : g_sel
      logic [IN_W-s-1:0] sel_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          sel_q <= '0;
        end else if (rdy && in_v) begin
          sel_q <= in_sel[IN_W-1:s];
        end
      end
    end
  end

  assign ready_o = g_stage[0].rdy;
  assign valid_o = g_stage[L-1].v_q;
  assign err_o   = g_stage[L-1].e_q;
  assign data_o  = g_stage[L-1].part_q[0];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n with three instances: full depth (s=5), depth 1000 (s=5),
// and a five-stage radix-4 tree that is driven with random traffic.
module tb_mux_pipe_n;
  localparam int unsigned N = 8;
  localparam int unsigned A = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] d_full [0:1023];
  logic [N-1:0] d_part [0:999];
  logic [N-1:0] d_deep [0:1023];
  logic [A-1:0] sel, sel_d;
  logic         valid, ready, valid_d, ready_d;
  logic         f_ready, f_valid, f_err;
  logic [N-1:0] f_data;
  logic         p_ready, p_valid, p_err;
  logic [N-1:0] p_data;
  logic         q_ready, q_valid, q_err;
  logic [N-1:0] q_data;

  mux_pipe_n #(.n(N), .address(A), .s(5), .depth(1024)) u_full (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d_full), .sel_i(sel), .valid_i(valid),
    .ready_o(f_ready), .data_o(f_data), .err_o(f_err), .valid_o(f_valid), .ready_i(ready));

  mux_pipe_n #(.n(N), .address(A), .s(5), .depth(1000)) u_part (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d_part), .sel_i(sel), .valid_i(valid),
    .ready_o(p_ready), .data_o(p_data), .err_o(p_err), .valid_o(p_valid), .ready_i(ready));

  mux_pipe_n #(.n(N), .address(A), .s(2), .depth(1024)) u_deep (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d_deep), .sel_i(sel_d), .valid_i(valid_d),
    .ready_o(q_ready), .data_o(q_data), .err_o(q_err), .valid_o(q_valid), .ready_i(ready_d));

  int vectors = 0;
  int miscompares = 0;
  logic [N:0] sb [$];  // {err, data} expected, pushed at acceptance

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; sel = '0;
    valid_d = 1'b0; ready_d = 1'b1; sel_d = '0;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if ({f_valid, f_err, f_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: valid=%b err=%b data=%h, required 0 0 00", f_valid, f_err, f_data);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (f_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: ready_o=%b, required 1", f_ready);
    end
    vectors++;
    if (q_valid !== 1'b0 || q_data !== '0) begin
      miscompares++; $display("FAIL reset_deep: valid=%b data=%h, required 0 00", q_valid, q_data);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk); sel = 10'd777; valid = 1'b1; ready = 1'b1; #1;
    vectors++;
    if (f_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_accept: ready_o=%b, required 1", f_ready);
    end
    @(negedge clk); valid = 1'b0; sel = '0; #1;
    vectors++;
    if (f_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_early: valid_o=%b, required 0", f_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (f_valid !== 1'b1 || f_err !== 1'b0 || f_data !== 8'h09) begin
      miscompares++;
      $display("FAIL single_data: valid=%b err=%b data=%h, required 1 0 09", f_valid, f_err, f_data);
    end
    @(negedge clk); #1;
    vectors++;
    if (f_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_once: valid_o=%b, required 0", f_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [A-1:0] reqs [$];
    logic [N:0]   want;
    int unsigned  outs, first;
    reqs = '{10'd0, 10'd1, 10'd1023, 10'd512};
    outs = 0; first = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      valid = (reqs.size() != 0); sel = valid ? reqs[0] : '0; ready = 1'b1; #1;
      if (f_valid) begin
        if (outs == 0) first = i;
        want = (sb.size() != 0) ? sb.pop_front() : 'x;
        vectors++;
        if ({f_err, f_data} !== want || i != first + outs) begin
          miscompares++;
          $display("FAIL b2b_out: err/data=%h at cycle %0d, required %h at cycle %0d", {f_err, f_data}, i, want, first + outs);
        end
        outs++;
      end
      if (valid) begin
        vectors++;
        if (f_ready !== 1'b1) begin
          miscompares++; $display("FAIL b2b_ready: ready_o=%b, required 1", f_ready);
        end else begin
          sb.push_back({1'b0, sel[7:0]});
          void'(reqs.pop_front());
        end
      end
    end
    vectors++;
    if (outs != 4 || first != 2) begin
      miscompares++; $display("FAIL b2b_count: outputs=%0d first=%0d, required 4 2", outs, first);
    end
  endtask

  task automatic test_backpressure();
    logic [A-1:0] reqs [$];
    logic [N:0]   want, held;
    logic         stalled;
    int unsigned  outs, low_at;
    reqs = '{10'd5, 10'd6, 10'd7};
    outs = 0; low_at = 99; stalled = 1'b0; held = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      valid = (reqs.size() != 0); sel = valid ? reqs[0] : '0; ready = (i >= 4); #1;
      if (stalled) begin
        vectors++;
        if (f_valid !== 1'b1 || {f_err, f_data} !== held) begin
          miscompares++;
          $display("FAIL bp_hold: valid=%b err/data=%h, required 1 %h", f_valid, {f_err, f_data}, held);
        end
      end
      if (f_valid && ready) begin
        want = (sb.size() != 0) ? sb.pop_front() : 'x;
        vectors++;
        if ({f_err, f_data} !== want) begin
          miscompares++; $display("FAIL bp_out: err/data=%h, required %h", {f_err, f_data}, want);
        end
        outs++;
      end
      if (valid && f_ready) begin
        sb.push_back({1'b0, sel[7:0]});
        void'(reqs.pop_front());
      end
      if (!f_ready && low_at == 99) low_at = i;
      stalled = f_valid && !ready;
      held = {f_err, f_data};
    end
    vectors++;
    if (outs != 3 || low_at != 2) begin
      miscompares++; $display("FAIL bp_summary: outputs=%0d ready_low_at=%0d, required 3 2", outs, low_at);
    end
  endtask

  task automatic test_out_of_range();
    logic [A-1:0] reqs [$];
    logic [N:0]   want;
    int unsigned  outs;
    reqs = '{10'd999, 10'd1000};
    outs = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      valid = (reqs.size() != 0); sel = valid ? reqs[0] : '0; ready = 1'b1; #1;
      if (p_valid) begin
        want = (sb.size() != 0) ? sb.pop_front() : 'x;
        vectors++;
        if ({p_err, p_data} !== want) begin
          miscompares++; $display("FAIL range_out: err/data=%h, required %h", {p_err, p_data}, want);
        end
        outs++;
      end
      if (valid && p_ready) begin
        sb.push_back((sel < 10'd1000) ? {1'b0, sel[7:0]} : {1'b1, 8'h00});
        void'(reqs.pop_front());
      end
    end
    vectors++;
    if (outs != 2) begin
      miscompares++; $display("FAIL range_count: outputs=%0d, required 2", outs);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); valid = 1'b1; sel = 10'd100; ready = 1'b0;
    @(negedge clk); sel = 10'd200;
    @(negedge clk); valid = 1'b0; sel = '0; rst_n = 1'b0; #1;
    vectors++;
    if (f_valid !== 1'b1 || f_data !== 8'h64) begin
      miscompares++; $display("FAIL mid_setup: valid=%b data=%h, required 1 64", f_valid, f_data);
    end
    @(negedge clk); rst_n = 1'b1; ready = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      vectors++;
      if (f_valid !== 1'b0) begin
        miscompares++; $display("FAIL mid_flush: valid_o=%b data=%h at idle cycle %0d, required 0", f_valid, f_data, i);
      end
    end
    @(negedge clk); valid = 1'b1; sel = 10'd300;
    @(negedge clk); valid = 1'b0; sel = '0;
    @(negedge clk); #1;
    vectors++;
    if (f_valid !== 1'b1 || f_data !== 8'h2C) begin
      miscompares++; $display("FAIL mid_recover: valid=%b data=%h, required 1 2c", f_valid, f_data);
    end
  endtask

  task automatic test_deep();
    logic [N-1:0] want_q [$];
    int unsigned  t_q [$];
    logic [N-1:0] want, held;
    int unsigned  t_acc;
    logic         stalled;
    stalled = 1'b0; held = '0;
    for (int unsigned i = 0; i < 10030; i++) begin
      @(negedge clk);
      for (int unsigned j = 0; j < 4; j++) d_deep[10'($urandom_range(1023, 0))] = N'($urandom);
      if (i < 10000) begin
        valid_d = ($urandom_range(9, 0) < 7);
        ready_d = ($urandom_range(9, 0) < 7);
        sel_d   = A'($urandom);
      end else begin
        valid_d = 1'b0; ready_d = 1'b1;
      end
      #1;
      if (stalled) begin
        vectors++;
        if (q_valid !== 1'b1 || q_data !== held) begin
          miscompares++; $display("FAIL deep_hold: valid=%b data=%h, required 1 %h", q_valid, q_data, held);
        end
      end
      if (q_valid && ready_d) begin
        want  = (want_q.size() != 0) ? want_q.pop_front() : 'x;
        t_acc = (t_q.size() != 0) ? t_q.pop_front() : i;
        vectors++;
        if (q_data !== want || q_err !== 1'b0 || i < t_acc + 5) begin
          miscompares++;
          $display("FAIL deep_out: data=%h err=%b latency=%0d, required %h 0 >=5", q_data, q_err, i - t_acc, want);
        end
      end
      if (valid_d && q_ready) begin
        want_q.push_back(d_deep[sel_d]);
        t_q.push_back(i);
      end
      stalled = q_valid && !ready_d;
      held = q_data;
    end
    vectors++;
    if (want_q.size() != 0) begin
      miscompares++; $display("FAIL deep_drain: %0d results outstanding, required 0", want_q.size());
    end
  endtask

  initial begin
    for (int unsigned k = 0; k < 1024; k++) begin
      d_full[k] = N'(k);
      d_deep[k] = N'(k * 7);
    end
    for (int unsigned k = 0; k < 1000; k++) d_part[k] = N'(k);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_midflight();
    test_deep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
